// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants and helpers for the pipelined adder.
//   OP_ADD / OP_SUB  encoding of the in_sub operation select
//   DEFAULT_WIDTH    default datapath width
//   DEFAULT_STAGES   default pipeline depth / slice count
//   slice_width()    bits handled by each pipeline slice
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational SW-bit adder slice with carry in/out.
//   a_i, b_i  slice operands
//   c_i       carry into the slice LSB
//   s_o       slice sum
//   c_o       carry out of the slice MSB
module adder_slice #(
    parameter int unsigned SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          c_i,
    output logic [SW-1:0] s_o,
    output logic          c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined A+B / A-B over WIDTH bits in STAGES carry-chained slices,
// one register stage per slice, valid/ready on both sides with a global stall.
//   Clk, Reset_n                clock, synchronous active-low reset
//   in_valid/in_ready           operand handshake (in_a, in_b, in_sub)
//   out_valid/out_ready         result handshake (out_sum, out_carry[, out_ovf])
//   out_carry                   MSB carry; for subtract 1 = no borrow
//   out_ovf                     signed overflow, only when PIPE_ADDER_OVF_EN is defined
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int unsigned SW = slice_width(WIDTH, STAGES);

    if (STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_err
        $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Stage registers; stage k holds the result after slice k has been added.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];

    // Inputs seen by each slice: stage 0 from the ports, stage k from register k-1.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [SW-1:0]     slice_s [STAGES];
    logic [STAGES-1:0] slice_c;

    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    always_comb begin
        src_v[0]   = in_valid;
        src_a[0]   = in_a;
        // Subtract as A + ~B + 1: invert B here and inject the +1 as carry-in.
        src_b[0]   = in_b ^ {WIDTH{in_sub == OP_SUB}};
        src_c[0]   = (in_sub == OP_SUB);
        src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = valid_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_c[k]   = carry_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
        // Lower result bits pass through; slice k fills in its own bits.
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k]              = src_sum[k];
            sum_d[k][k*SW +: SW]  = slice_s[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .SW (SW)
        ) u_slice (
            .a_i (src_a[k][k*SW +: SW]),
            .b_i (src_b[k][k*SW +: SW]),
            .c_i (src_c[k]),
            .s_o (slice_s[k]),
            .c_o (slice_c[k])
        );
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= src_v;
            // Bubbles only clear the valid bit; data is loaded for real operations only.
            for (int k = 0; k < STAGES; k++) begin
                if (src_v[k]) begin
                    a_q[k]     <= src_a[k];
                    b_q[k]     <= src_b[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= slice_c[k];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_carry = carry_q[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
    // Operand sign bits (B already inverted) travel with the data to the last stage.
    logic [STAGES-1:0] sa_q;
    logic [STAGES-1:0] sb_q;
    logic [STAGES-1:0] src_sa;
    logic [STAGES-1:0] src_sb;

    always_comb begin
        src_sa[0] = src_a[0][WIDTH-1];
        src_sb[0] = src_b[0][WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            src_sa[k] = sa_q[k-1];
            src_sb[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sa_q <= '0;
            sb_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                if (src_v[k]) begin
                    sa_q[k] <= src_sa[k];
                    sb_q[k] <= src_sb[k];
                end
            end
        end
    end

    assign out_ovf = (sa_q[STAGES-1] == sb_q[STAGES-1]) &
                     (out_sum[WIDTH-1] != sa_q[STAGES-1]);
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder. Three instances (32/4, 16/1, 32/8)
// run concurrently; each has a push process, a monitor process and a stimulus thread.
// Build with PIPE_ADDER_OVF_EN defined to also check out_ovf.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;
    int n_done  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_h
        localparam int unsigned W = (g == 1) ? 16 : 32;
        localparam int unsigned S = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] in_a;
        logic [W-1:0] in_b;
        logic         in_sub;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] out_sum;
        logic         out_carry;
`ifdef PIPE_ADDER_OVF_EN
        logic         out_ovf;
`endif

        // Scoreboard: one entry per accepted operation.
        logic [W-1:0] q_sum [$];
        logic         q_car [$];
        logic         q_ovf [$];
        int           q_acc [$];
        bit           q_lat [$];
        bit           lat_chk = 1'b1;
        int           popped  = 0;

        pipe_adder #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_dut (
            .Clk       (clk),
            .Reset_n   (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_sub    (in_sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_sum   (out_sum),
            .out_carry (out_carry)
`ifdef PIPE_ADDER_OVF_EN
            ,
            .out_ovf   (out_ovf)
`endif
        );

        // Reference: plain integer arithmetic on unsigned and signed interpretations.
        task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                             output logic [W-1:0] s, output logic c, output logic o);
            longint unsigned ua   = 64'(a);
            longint unsigned ub   = 64'(b);
            longint unsigned full;
            longint          sa   = longint'(ua) - (a[W-1] ? (longint'(1) <<< W) : 0);
            longint          sbv  = longint'(ub) - (b[W-1] ? (longint'(1) <<< W) : 0);
            longint          lim  = longint'(1) <<< (W - 1);
            longint          r;
            if (sub) begin
                full = ua - ub;
                c    = (ua >= ub);
                r    = sa - sbv;
            end else begin
                full = ua + ub;
                c    = ((full >> W) != 0);
                r    = sa + sbv;
            end
            s = W'(full);
            o = (r >= lim) || (r < -lim);
        endtask

        // Push: an operation present at the negedge is accepted at the next posedge.
        always @(negedge clk) begin
            logic [W-1:0] s;
            logic         c;
            logic         o;
            if (!rst_n) begin
                q_sum.delete(); q_car.delete(); q_ovf.delete(); q_acc.delete(); q_lat.delete();
            end else if (in_valid && in_ready) begin
                model(in_a, in_b, in_sub, s, c, o);
                q_sum.push_back(s);
                q_car.push_back(c);
                q_ovf.push_back(o);
                q_acc.push_back(cyc);
                q_lat.push_back(lat_chk);
            end
        end

        // Monitor: compare every transferred result against the scoreboard head.
        always @(negedge clk) begin
            if (rst_n && out_valid && out_ready) begin
                chk($sformatf("inst%0d output_expected", g), 64'(q_sum.size() != 0), 64'd1);
                if (q_sum.size() != 0) begin
                    chk($sformatf("inst%0d sum", g), 64'(out_sum), 64'(q_sum[0]));
                    chk($sformatf("inst%0d carry", g), 64'(out_carry), 64'(q_car[0]));
`ifdef PIPE_ADDER_OVF_EN
                    chk($sformatf("inst%0d ovf", g), 64'(out_ovf), 64'(q_ovf[0]));
`endif
                    if (q_lat[0]) chk($sformatf("inst%0d latency", g), 64'(cyc - q_acc[0]), 64'(S));
                    void'(q_sum.pop_front()); void'(q_car.pop_front()); void'(q_ovf.pop_front());
                    void'(q_acc.pop_front()); void'(q_lat.pop_front());
                    popped++;
                end
            end
        end

        function automatic logic [W-1:0] rnd_op();
            case ($urandom_range(0, 5))
                0:       return '1;
                1:       return '0;
                2:       return {1'b1, {(W-1){1'b0}}};
                default: return W'($urandom);
            endcase
        endfunction

        task automatic do_reset();
            rst_n     = 1'b0;
            in_valid  = 1'b1;  // must be ignored while in reset
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_sub    = 1'b0;
            out_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        endtask

        task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
            bit got = 1'b0;
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            in_sub   = sub;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                got = in_ready;
            end
            if (!got) chk($sformatf("inst%0d issue_timeout", g), 64'(got), 64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic drain();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int t = 0; t < 500; t++) begin
                @(negedge clk);
                if (q_sum.size() == 0 && !out_valid) break;
            end
            chk($sformatf("inst%0d drained", g), 64'(q_sum.size()), 64'd0);
            @(posedge clk);
            #1;
        endtask

        if (g == 0) begin : g_dir
            initial begin
                int           issued;
                int           hold;
                int           p0;
                bit           seen;
                logic [W-1:0] held_sum;
                logic         held_c;

                do_reset();
                chk("reset out_valid", 64'(out_valid), 64'd0);
                chk("reset out_sum", 64'(out_sum), 64'd0);
                chk("reset out_carry", 64'(out_carry), 64'd0);
                chk("reset in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_ADDER_OVF_EN
                chk("reset out_ovf", 64'(out_ovf), 64'd0);
`endif
                rst_n    = 1'b1;
                in_valid = 1'b0;

                issue(32'h0040_0000, 32'h0000_0010, OP_ADD);
                drain();
                issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
                issue(32'h0000_0005, 32'h0000_0007, OP_SUB);
                issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
                issue(32'h8000_0000, 32'h0000_0001, OP_SUB);
                issue(32'h0000_0005, 32'h0000_0003, OP_SUB);
                drain();

                // Back-pressure: 6 back-to-back ops, stall 3 cycles once output is valid.
                lat_chk  = 1'b0;
                issued   = 0;
                hold     = 0;
                seen     = 1'b0;
                p0       = popped;
                held_sum = '0;
                held_c   = 1'b0;
                for (int c = 0; c < 100 && (issued < 6 || hold < 3); c++) begin
                    in_valid = (issued < 6);
                    in_a     = rnd_op();
                    in_b     = rnd_op();
                    in_sub   = 1'($urandom_range(0, 1));
                    out_ready = !(seen && hold < 3);
                    @(negedge clk);
                    if (!out_ready) begin
                        chk("bp in_ready", 64'(in_ready), 64'd0);
                        chk("bp out_valid", 64'(out_valid), 64'd1);
                        if (hold == 0) begin
                            held_sum = out_sum;
                            held_c   = out_carry;
                        end else begin
                            chk("bp sum_stable", 64'(out_sum), 64'(held_sum));
                            chk("bp carry_stable", 64'(out_carry), 64'(held_c));
                        end
                        hold++;
                    end else if (out_valid) begin
                        seen = 1'b1;
                    end
                    if (in_valid && in_ready) issued++;
                    @(posedge clk);
                    #1;
                end
                drain();
                chk("bp delivered", 64'(popped - p0), 64'd6);
                lat_chk = 1'b1;

                // Reset mid-flight: three ops in the pipe are discarded.
                p0 = popped;
                issue(rnd_op(), rnd_op(), OP_ADD);
                issue(rnd_op(), rnd_op(), OP_SUB);
                issue(rnd_op(), rnd_op(), OP_ADD);
                rst_n    = 1'b0;
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                rst_n    = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                chk("midrst out_valid", 64'(out_valid), 64'd0);
                chk("midrst out_sum", 64'(out_sum), 64'd0);
                chk("midrst in_ready", 64'(in_ready), 64'd1);
                for (int t = 0; t < 10; t++) begin
                    @(negedge clk);
                    chk("midrst no_stale", 64'(out_valid), 64'd0);
                end
                chk("midrst none_delivered", 64'(popped - p0), 64'd0);
                @(posedge clk);
                #1;

                // Random traffic with random back-pressure.
                lat_chk = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 3) != 0);
                    in_a      = rnd_op();
                    in_b      = rnd_op();
                    in_sub    = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                drain();
                lat_chk = 1'b1;
                n_done++;
            end
        end else begin : g_sweep
            initial begin
                int acc = 0;
                do_reset();
                rst_n    = 1'b1;
                in_valid = 1'b0;
                for (int c = 0; c < 5000 && acc < 1000; c++) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_a     = rnd_op();
                    in_b     = rnd_op();
                    in_sub   = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (in_valid && in_ready) acc++;
                    @(posedge clk);
                    #1;
                end
                drain();
                chk($sformatf("inst%0d sweep_count", g), 64'(popped), 64'd1000);
                n_done++;
            end
        end
    end

    initial begin
        for (int c = 0; c < 60000 && n_done < 3; c++) @(posedge clk);
        if (n_done < 3) chk("all_threads_done", 64'(n_done), 64'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined successor to the single-cycle PC/immediate adder. It computes A+B or A−B over a WIDTH-bit datapath split into STAGES carry-chained slices, with one register stage per slice. A valid/ready handshake on each side allows back-pressure. It serves the branch-target and address-generation paths, where the carry chain no longer closes timing in one cycle.

## Interface
- WIDTH, 32: operand and result width; must be divisible by STAGES.
- STAGES, 4: pipeline depth and slice count; slice width SW = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.
- Clk  input  1  single clock; all state updates on rising edge.
- Reset_n  input  1  reset; synchronous and active-low.
- in_valid  input  1  operand set on in_a/in_b/in_sub is valid.
- in_ready  output  1  block accepts the operand set this cycle.
- in_a  input  WIDTH  operand A (PC or base).
- in_b  input  WIDTH  operand B (immediate or offset).
- in_sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result on out_sum/out_carry is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  carry out of the MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- out_ovf  output  1  signed overflow; present only when PIPE_ADDER_OVF_EN is defined.

## Operation
- Subtract is implemented as A + ~B + 1: B is inverted at entry and carry-in = in_sub.
- Stage k (0..STAGES−1) adds bits [k·SW +: SW] of A and B′ plus the carry registered by stage k−1.
- Unconsumed upper operand bits travel skewed with the data; completed lower result bits travel forward unchanged.
- Global stall: advance = ~out_valid | out_ready; in_ready = advance.
- When advance = 0, every stage register, including valid bits, holds.
- When advance = 1, every stage shifts by one; a stage whose predecessor is empty loads a bubble (valid = 0).
- Accept occurs on in_valid & in_ready; transfer on out_valid & out_ready.
- in_a/in_b/in_sub are sampled only on accept; values on non-accept cycles are ignored.
- Results leave in issue order; no reordering, no dropping while Reset_n = 1.
- Arithmetic is unsigned modulo 2^WIDTH; out_carry is the final slice carry.
- With OVF, out_ovf = (A[MSB] == B′[MSB]) & (sum[MSB] != A[MSB]), with A[MSB] and B′[MSB] carried to the last stage.
- No FSM: state is the STAGES-deep valid shift register plus data and carry registers.

## Timing
- Latency is STAGES cycles from accept to out_valid, with out_ready held high.
- Throughput is one result per cycle with out_ready held high; bubbles propagate unchanged.
- Reset_n = 0 at an edge clears every stage valid bit, data register, carry register and the out_ovf source to 0.
- Reset values: out_valid = 0, out_sum = 0, out_carry = 0, out_ovf = 0, in_ready = 1 (combinational, since out_valid = 0).
- Reset mid-operation: all in-flight operations are discarded; no output appears for them.
- in_valid is ignored on reset cycles.
- Simultaneous accept and transfer in one cycle is legal; occupancy is unchanged.
- While out_valid = 1 and out_ready = 0, out_sum/out_carry/out_ovf stay stable, and in_ready = 0 even if earlier stages hold bubbles.
- STAGES = 1 degenerates to a registered adder with 1-cycle latency.

## Configuration
- PIPE_ADDER_OVF_EN defined: the out_ovf port exists, and the operand sign bits are pipelined to the last stage to compute signed overflow.
- PIPE_ADDER_OVF_EN undefined: the out_ovf port and its sign-bit registers are absent; all other behaviour is identical.

## Structure
- Shared package pipe_adder_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - default WIDTH/STAGES constants;
  - a slice-width helper function.
- Sub-module adder_slice: combinational SW-bit add with carry in and carry out.
- pipe_adder instantiates STAGES copies of adder_slice in a generate loop.
- pipe_adder owns all registers and the handshake logic.

## Test plan
- Defaults, out_ready = 1: A = 0x00400000, B = 0x00000010, add → out_sum 0x00400010, carry 0, exactly 4 cycles after accept.
- Slice carry ripple: A = 0xFFFFFFFF, B = 0x00000001, add → 0x00000000, carry 1; then A = 0x00000005, B = 0x00000007, sub → 0xFFFFFFFE, carry 0.
- OVF build: A = 0x7FFFFFFF, B = 1, add → out_ovf 1; A = 0x80000000, B = 1, sub → out_ovf 1; A = 5, B = 3, sub → out_ovf 0.
- Back-pressure: issue 6 back-to-back ops; hold out_ready = 0 for 3 cycles once the first is valid.
  - Required: in_ready = 0 during the hold, output stable, all 6 results delivered in order, none lost or duplicated.
- Reset mid-flight: accept 3 ops, assert Reset_n = 0 for one edge.
  - Required: out_valid = 0 and out_sum = 0 next cycle, no stale results afterwards, in_ready = 1.
- Parameter sweep: WIDTH = 16/STAGES = 1 and WIDTH = 32/STAGES = 8, 1000 random ops each.
  - Required: match a reference model; latency = STAGES.
